wired_lsu_iq_fifo: RTL and testbench

- Parametrised in-order issue queue for the LSU.
- Circular FIFO with head/tail pointers; accepts up to DISPATCH_W instructions per cycle from the dispatch (P) stage.
- Snoops CDB_W CDB lanes to wake pending operands.
- Issues strictly from the head to the LSU pipeline over a valid/ready handshake.
- Generalises the fixed 2-wide LSU queue in depth, dispatch width and CDB lane count, and adds same-cycle dispatch wakeup.

---
 rtl/wired_lsu_iq_fifo_pkg.sv | 35 +++
 rtl/wired_iq_wkup.sv | 40 ++++
 rtl/wired_lsu_iq_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_wired_lsu_iq_fifo.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wired_lsu_iq_fifo_pkg.sv
// ----------------------------------------------------------------------------
// wired_lsu_iq_fifo_pkg
//   Shared definitions for the LSU issue queue: parameter defaults, the
//   pointer type and the entry layout for the default configuration.
//   The queue itself re-declares the entry with its own parameter widths, so
//   lsu_iq_entry_t here documents the default layout (ctrl, data[2], tag[2],
//   rdy[2]).
//   Operand index 0 is the base address operand, index 1 is store data.
// ----------------------------------------------------------------------------
`ifndef _WIRED_PARAM_INT_IQ_DEPTH
`define _WIRED_PARAM_INT_IQ_DEPTH 8
`endif

package wired_lsu_iq_fifo_pkg;

    localparam int WIRED_IQ_DEPTH   = `_WIRED_PARAM_INT_IQ_DEPTH;
    localparam int WIRED_DISPATCH_W = 2;
    localparam int WIRED_CDB_W      = 2;
    localparam int WIRED_DATA_W     = 32;
    localparam int WIRED_TAG_W      = 6;
    localparam int WIRED_CTRL_W     = 64;

    // Index bits plus one wrap bit.
    localparam int WIRED_IQ_PTR_W   = $clog2(WIRED_IQ_DEPTH) + 1;

    typedef logic [WIRED_IQ_PTR_W-1:0] lsu_iq_ptr_t;

    typedef struct packed {
        logic [WIRED_CTRL_W-1:0]      ctrl;
        logic [1:0][WIRED_DATA_W-1:0] data;
        logic [1:0][WIRED_TAG_W-1:0]  tag;
        logic [1:0]                   rdy;
    } lsu_iq_entry_t;

endpackage

// File: rtl/wired_iq_wkup.sv
// ----------------------------------------------------------------------------
// wired_iq_wkup
//   Single-operand wakeup comparator: matches one producer tag against all
//   CDB lanes. When several lanes match, the lowest lane index wins.
// Ports:
//   tag_i        operand producer tag
//   cdb_valid_i  per-lane CDB valid
//   cdb_tag_i    packed CDB tags (lane i at [i*TAG_W +: TAG_W])
//   cdb_data_i   packed CDB data (lane i at [i*DATA_W +: DATA_W])
//   hit_o        some valid lane carries tag_i
//   data_o       data of the winning lane (0 when no hit)
// ----------------------------------------------------------------------------
module wired_iq_wkup
    import wired_lsu_iq_fifo_pkg::*;
#(
    parameter int CDB_W  = WIRED_CDB_W,
    parameter int TAG_W  = WIRED_TAG_W,
    parameter int DATA_W = WIRED_DATA_W
) (
    input  logic [TAG_W-1:0]        tag_i,
    input  logic [CDB_W-1:0]        cdb_valid_i,
    input  logic [CDB_W*TAG_W-1:0]  cdb_tag_i,
    input  logic [CDB_W*DATA_W-1:0] cdb_data_i,
    output logic                    hit_o,
    output logic [DATA_W-1:0]       data_o
);

    // Scan from the top lane down so the lowest matching lane is written last.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int i = CDB_W - 1; i >= 0; i--) begin
            if (cdb_valid_i[i] && (cdb_tag_i[i*TAG_W +: TAG_W] == tag_i)) begin
                hit_o  = 1'b1;
                data_o = cdb_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/wired_lsu_iq_fifo.sv
// ----------------------------------------------------------------------------
// wired_lsu_iq_fifo
//   In-order LSU issue queue. Circular buffer with wrap-bit pointers, up to
//   DISPATCH_W packed enqueues per cycle, CDB snooping for pending operands
//   (including operands arriving in the same cycle as their broadcast), and
//   strictly in-order issue from the head over valid/ready.
//   Optional macro WIRED_LSU_IQ_CDB_BYPASS_EN: a head operand matching the CDB
//   in the current cycle counts as ready and forwards the CDB data.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   p_valid_i/ctrl/data/rdy/tag  dispatch lanes (operand 0 base, 1 store data)
//   p_ready_o           room for a full dispatch group and no flush
//   cdb_valid_i/tag/data  CDB snoop lanes
//   iss_valid_o/ready_i   issue handshake; iss_ctrl_o/iss_data_o head payload
//   flush_i             drain head entries without waiting for operands
//   count_o             occupied entries
// ----------------------------------------------------------------------------
module wired_lsu_iq_fifo
    import wired_lsu_iq_fifo_pkg::*;
#(
    parameter int IQ_SIZE    = WIRED_IQ_DEPTH,
    parameter int DISPATCH_W = WIRED_DISPATCH_W,
    parameter int CDB_W      = WIRED_CDB_W,
    parameter int DATA_W     = WIRED_DATA_W,
    parameter int TAG_W      = WIRED_TAG_W,
    parameter int CTRL_W     = WIRED_CTRL_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DISPATCH_W-1:0]          p_valid_i,
    input  logic [DISPATCH_W*CTRL_W-1:0]   p_ctrl_i,
    input  logic [DISPATCH_W*2*DATA_W-1:0] p_data_i,
    input  logic [DISPATCH_W*2-1:0]        p_rdy_i,
    input  logic [DISPATCH_W*2*TAG_W-1:0]  p_tag_i,
    output logic                           p_ready_o,
    input  logic [CDB_W-1:0]               cdb_valid_i,
    input  logic [CDB_W*TAG_W-1:0]         cdb_tag_i,
    input  logic [CDB_W*DATA_W-1:0]        cdb_data_i,
    output logic                           iss_valid_o,
    input  logic                           iss_ready_i,
    output logic [CTRL_W-1:0]              iss_ctrl_o,
    output logic [2*DATA_W-1:0]            iss_data_o,
    input  logic                           flush_i,
    output logic [$clog2(IQ_SIZE+1)-1:0]   count_o
);

    localparam int IDX_W = $clog2(IQ_SIZE);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(IQ_SIZE + 1);

    typedef struct packed {
        logic [CTRL_W-1:0]      ctrl;
        logic [1:0][DATA_W-1:0] data;
        logic [1:0][TAG_W-1:0]  tag;
        logic [1:0]             rdy;
    } entry_t;

    entry_t           ent_q   [IQ_SIZE];
    entry_t           ent_nxt [IQ_SIZE];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    logic             ent_hit    [IQ_SIZE][2];
    logic [DATA_W-1:0] ent_hdata [IQ_SIZE][2];
    logic             disp_hit   [DISPATCH_W][2];
    logic [DATA_W-1:0] disp_hdata [DISPATCH_W][2];

    logic [CNT_W-1:0] enq_cnt;
    logic [IDX_W-1:0] lane_idx [DISPATCH_W];
    logic             enq_fire, deq, empty;
    logic [IDX_W-1:0] head_idx;
    logic [1:0]       op_rdy;
    logic [DATA_W-1:0] op_data [2];

    genvar ge, gl, go;
    generate
        for (ge = 0; ge < IQ_SIZE; ge++) begin : g_ent
            for (go = 0; go < 2; go++) begin : g_op
                wired_iq_wkup #(.CDB_W(CDB_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_wkup (
                    .tag_i       (ent_q[ge].tag[go]),
                    .cdb_valid_i (cdb_valid_i),
                    .cdb_tag_i   (cdb_tag_i),
                    .cdb_data_i  (cdb_data_i),
                    .hit_o       (ent_hit[ge][go]),
                    .data_o      (ent_hdata[ge][go])
                );
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) ent_q[ge] <= '0;
                else        ent_q[ge] <= ent_nxt[ge];
            end
        end
        for (gl = 0; gl < DISPATCH_W; gl++) begin : g_disp
            for (go = 0; go < 2; go++) begin : g_op
                wired_iq_wkup #(.CDB_W(CDB_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_wkup (
                    .tag_i       (p_tag_i[(2*gl+go)*TAG_W +: TAG_W]),
                    .cdb_valid_i (cdb_valid_i),
                    .cdb_tag_i   (cdb_tag_i),
                    .cdb_data_i  (cdb_data_i),
                    .hit_o       (disp_hit[gl][go]),
                    .data_o      (disp_hdata[gl][go])
                );
            end
        end
    endgenerate

    assign head_idx  = head_q[IDX_W-1:0];
    assign empty     = (head_q == tail_q);
    assign p_ready_o = (count_q <= CNT_W'(IQ_SIZE - DISPATCH_W)) && !flush_i;
    assign enq_fire  = p_ready_o;
    assign deq       = iss_valid_o && iss_ready_i;
    assign count_o   = count_q;

    // Valid lanes are packed: each lane lands at tail plus the number of
    // valid lanes below it.
    always_comb begin
        enq_cnt = '0;
        for (int l = 0; l < DISPATCH_W; l++) begin
            lane_idx[l] = tail_q[IDX_W-1:0] + enq_cnt[IDX_W-1:0];
            if (p_valid_i[l]) enq_cnt = enq_cnt + CNT_W'(1);
        end
    end

    // Next entry state: stored wakeup first, then enqueue writes. Enqueued
    // slots are always free, so the two never target a live entry together.
    always_comb begin
        for (int e = 0; e < IQ_SIZE; e++) begin
            ent_nxt[e] = ent_q[e];
            for (int o = 0; o < 2; o++) begin
                if (!ent_q[e].rdy[o] && ent_hit[e][o]) begin
                    ent_nxt[e].rdy[o]  = 1'b1;
                    ent_nxt[e].data[o] = ent_hdata[e][o];
                end
            end
            for (int l = 0; l < DISPATCH_W; l++) begin
                if (enq_fire && p_valid_i[l] && (lane_idx[l] == IDX_W'(e))) begin
                    ent_nxt[e].ctrl = p_ctrl_i[l*CTRL_W +: CTRL_W];
                    for (int o = 0; o < 2; o++) begin
                        ent_nxt[e].tag[o] = p_tag_i[(2*l+o)*TAG_W +: TAG_W];
                        if (p_rdy_i[2*l+o]) begin
                            ent_nxt[e].rdy[o]  = 1'b1;
                            ent_nxt[e].data[o] = p_data_i[(2*l+o)*DATA_W +: DATA_W];
                        end else if (disp_hit[l][o]) begin
                            ent_nxt[e].rdy[o]  = 1'b1;
                            ent_nxt[e].data[o] = disp_hdata[l][o];
                        end else begin
                            ent_nxt[e].rdy[o]  = 1'b0;
                            ent_nxt[e].data[o] = p_data_i[(2*l+o)*DATA_W +: DATA_W];
                        end
                    end
                end
            end
        end
    end

`ifdef WIRED_LSU_IQ_CDB_BYPASS_EN
    logic             head_hit   [2];
    logic [DATA_W-1:0] head_hdata [2];
    generate
        for (go = 0; go < 2; go++) begin : g_head
            wired_iq_wkup #(.CDB_W(CDB_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_wkup (
                .tag_i       (ent_q[head_idx].tag[go]),
                .cdb_valid_i (cdb_valid_i),
                .cdb_tag_i   (cdb_tag_i),
                .cdb_data_i  (cdb_data_i),
                .hit_o       (head_hit[go]),
                .data_o      (head_hdata[go])
            );
        end
    endgenerate

    always_comb begin
        for (int o = 0; o < 2; o++) begin
            op_rdy[o]  = ent_q[head_idx].rdy[o] || head_hit[o];
            op_data[o] = (!ent_q[head_idx].rdy[o] && head_hit[o]) ? head_hdata[o]
                                                                  : ent_q[head_idx].data[o];
        end
    end
`else
    always_comb begin
        for (int o = 0; o < 2; o++) begin
            op_rdy[o]  = ent_q[head_idx].rdy[o];
            op_data[o] = ent_q[head_idx].data[o];
        end
    end
`endif

    assign iss_valid_o = !empty && ((op_rdy[0] && op_rdy[1]) || flush_i);
    assign iss_ctrl_o  = ent_q[head_idx].ctrl;
    assign iss_data_o  = {op_data[1], op_data[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (deq)      head_q <= head_q + PTR_W'(1);
            if (enq_fire) tail_q <= tail_q + PTR_W'(enq_cnt);
            count_q <= count_q + (enq_fire ? enq_cnt : '0) - CNT_W'(deq);
        end
    end

endmodule

// File: tb/tb_wired_lsu_iq_fifo.sv
// ----------------------------------------------------------------------------
// tb_wired_lsu_iq_fifo
//   Directed scenarios plus a randomized run against a queue-based reference
//   model of the LSU issue queue (default parameters).
// ----------------------------------------------------------------------------
module tb_wired_lsu_iq_fifo;

    localparam int IQ_SIZE = 8;
    localparam int DW      = 2;
    localparam int CW      = 2;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 6;
    localparam int CTRL_W  = 64;
    localparam int CNT_W   = 4;

    logic                     clk;
    logic                     rst_n;
    logic [DW-1:0]            p_valid_i;
    logic [DW*CTRL_W-1:0]     p_ctrl_i;
    logic [DW*2*DATA_W-1:0]   p_data_i;
    logic [DW*2-1:0]          p_rdy_i;
    logic [DW*2*TAG_W-1:0]    p_tag_i;
    logic                     p_ready_o;
    logic [CW-1:0]            cdb_valid_i;
    logic [CW*TAG_W-1:0]      cdb_tag_i;
    logic [CW*DATA_W-1:0]     cdb_data_i;
    logic                     iss_valid_o;
    logic                     iss_ready_i;
    logic [CTRL_W-1:0]        iss_ctrl_o;
    logic [2*DATA_W-1:0]      iss_data_o;
    logic                     flush_i;
    logic [CNT_W-1:0]         count_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [CTRL_W-1:0]      c;
        logic [1:0][DATA_W-1:0] d;
        logic [1:0][TAG_W-1:0]  t;
        logic [1:0]             r;
    } ment_t;

    ment_t mq[$];

    wired_lsu_iq_fifo dut (
        .clk(clk), .rst_n(rst_n),
        .p_valid_i(p_valid_i), .p_ctrl_i(p_ctrl_i), .p_data_i(p_data_i),
        .p_rdy_i(p_rdy_i), .p_tag_i(p_tag_i), .p_ready_o(p_ready_o),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
        .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
        .iss_ctrl_o(iss_ctrl_o), .iss_data_o(iss_data_o),
        .flush_i(flush_i), .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        p_valid_i = '0; p_ctrl_i = '0; p_data_i = '0; p_rdy_i = '0; p_tag_i = '0;
        cdb_valid_i = '0; cdb_tag_i = '0; cdb_data_i = '0;
        iss_ready_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic set_lane(input int l, input logic [CTRL_W-1:0] c,
                            input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                            input logic r0, input logic r1,
                            input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1);
        p_valid_i[l] = 1'b1;
        p_ctrl_i[l*CTRL_W +: CTRL_W]     = c;
        p_data_i[(2*l)*DATA_W +: DATA_W]   = d0;
        p_data_i[(2*l+1)*DATA_W +: DATA_W] = d1;
        p_rdy_i[2*l]   = r0;
        p_rdy_i[2*l+1] = r1;
        p_tag_i[(2*l)*TAG_W +: TAG_W]   = t0;
        p_tag_i[(2*l+1)*TAG_W +: TAG_W] = t1;
    endtask

    task automatic set_cdb(input int l, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        cdb_valid_i[l] = 1'b1;
        cdb_tag_i[l*TAG_W +: TAG_W]    = t;
        cdb_data_i[l*DATA_W +: DATA_W] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        mq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Lowest valid CDB lane carrying tag t.
    function automatic bit cdb_lookup(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
        bit found = 1'b0;
        d = '0;
        for (int i = 0; i < CW; i++) begin
            if (!found && cdb_valid_i[i] && cdb_tag_i[i*TAG_W +: TAG_W] == t) begin
                found = 1'b1;
                d = cdb_data_i[i*DATA_W +: DATA_W];
            end
        end
        return found;
    endfunction

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_o); end
        n_cmp++; if (p_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_pready: got %0b want 1", p_ready_o); end
        n_cmp++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_issv: got %0b want 0", iss_valid_o); end
        next_cycle();
        set_lane(0, 64'h1, 32'h1, 32'h2, 1'b1, 1'b1, 6'd0, 6'd0);
        set_lane(1, 64'h2, 32'h3, 32'h4, 1'b1, 1'b1, 6'd0, 6'd0);
        next_cycle();
        drive_idle();
        #1;
        n_cmp++; if (count_o !== 4'd2) begin n_fail++; $display("FAIL reset_precount: got %0d want 2", count_o); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d want 0", count_o); end
        n_cmp++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_issv: got %0b want 0", iss_valid_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_issue();
        do_reset();
        set_lane(0, 64'hA0, 32'h100, 32'h101, 1'b1, 1'b1, 6'd0, 6'd0);
        set_lane(1, 64'hB1, 32'h200, 32'h201, 1'b1, 1'b1, 6'd0, 6'd0);
        iss_ready_i = 1'b1;
        #1;
        n_cmp++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_empty_issv: got %0b want 0", iss_valid_o); end
        next_cycle();
        drive_idle(); iss_ready_i = 1'b1;
        #1;
        n_cmp++; if (count_o !== 4'd2) begin n_fail++; $display("FAIL basic_cnt2: got %0d want 2", count_o); end
        n_cmp++; if (iss_valid_o !== 1'b1 || iss_ctrl_o !== 64'hA0) begin n_fail++; $display("FAIL basic_lane0: got v=%0b ctrl=%0h want v=1 ctrl=a0", iss_valid_o, iss_ctrl_o); end
        n_cmp++; if (iss_data_o !== {32'h101, 32'h100}) begin n_fail++; $display("FAIL basic_data0: got %0h want 0000010100000100", iss_data_o); end
        next_cycle();
        #1;
        n_cmp++; if (count_o !== 4'd1) begin n_fail++; $display("FAIL basic_cnt1: got %0d want 1", count_o); end
        n_cmp++; if (iss_valid_o !== 1'b1 || iss_ctrl_o !== 64'hB1) begin n_fail++; $display("FAIL basic_lane1: got v=%0b ctrl=%0h want v=1 ctrl=b1", iss_valid_o, iss_ctrl_o); end
        next_cycle();
        #1;
        n_cmp++; if (count_o !== 4'd0 || iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_cnt0: got cnt=%0d v=%0b want cnt=0 v=0", count_o, iss_valid_o); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int g = 0; g < 4; g++) begin
            drive_idle();
            set_lane(0, 64'(2*g),   32'h0, 32'h0, 1'b1, 1'b1, 6'd0, 6'd0);
            set_lane(1, 64'(2*g+1), 32'h0, 32'h0, 1'b1, 1'b1, 6'd0, 6'd0);
            #1;
            n_cmp++; if (p_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_pready_g%0d: got %0b want 1", g, p_ready_o); end
            next_cycle();
        end
        drive_idle();
        set_lane(0, 64'hFF, 32'h0, 32'h0, 1'b1, 1'b1, 6'd0, 6'd0);
        #1;
        n_cmp++; if (count_o !== 4'd8 || p_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_full: got cnt=%0d prdy=%0b want cnt=8 prdy=0", count_o, p_ready_o); end
        iss_ready_i = 1'b1;
        next_cycle();
        drive_idle(); iss_ready_i = 1'b1;
        #1;
        n_cmp++; if (count_o !== 4'd7 || p_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_seven: got cnt=%0d prdy=%0b want cnt=7 prdy=0", count_o, p_ready_o); end
        for (int k = 1; k < 8; k++) begin
            n_cmp++; if (iss_valid_o !== 1'b1 || iss_ctrl_o !== 64'(k)) begin n_fail++; $display("FAIL fill_drain_%0d: got v=%0b ctrl=%0h want v=1 ctrl=%0h", k, iss_valid_o, iss_ctrl_o, k); end
            next_cycle();
        end
        n_cmp++; if (count_o !== 4'd0 || p_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_empty: got cnt=%0d prdy=%0b want cnt=0 prdy=1", count_o, p_ready_o); end
    endtask

    task automatic test_stored_wakeup();
        do_reset();
        set_lane(0, 64'h10, 32'h0, 32'h55, 1'b0, 1'b1, 6'd5, 6'd0);
        set_lane(1, 64'h11, 32'hA, 32'hB, 1'b1, 1'b1, 6'd0, 6'd0);
        iss_ready_i = 1'b1;
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            drive_idle(); iss_ready_i = 1'b1;
            #1;
            n_cmp++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL wake_stall_%0d: got %0b want 0", c, iss_valid_o); end
            next_cycle();
        end
        drive_idle(); iss_ready_i = 1'b1;
        set_cdb(0, 6'd6, 32'h0BAD);
        set_cdb(1, 6'd5, 32'hDEADBEEF);
        #1;
`ifdef WIRED_LSU_IQ_CDB_BYPASS_EN
        n_cmp++; if (iss_valid_o !== 1'b1 || iss_ctrl_o !== 64'h10) begin n_fail++; $display("FAIL wake_bypass_issue: got v=%0b ctrl=%0h want v=1 ctrl=10", iss_valid_o, iss_ctrl_o); end
        n_cmp++; if (iss_data_o[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wake_bypass_data: got %0h want deadbeef", iss_data_o[31:0]); end
        next_cycle();
        drive_idle(); iss_ready_i = 1'b1;
        #1;
`else
        n_cmp++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL wake_same_cycle: got %0b want 0", iss_valid_o); end
        next_cycle();
        drive_idle(); iss_ready_i = 1'b1;
        #1;
        n_cmp++; if (iss_valid_o !== 1'b1 || iss_ctrl_o !== 64'h10) begin n_fail++; $display("FAIL wake_issue: got v=%0b ctrl=%0h want v=1 ctrl=10", iss_valid_o, iss_ctrl_o); end
        n_cmp++; if (iss_data_o !== {32'h55, 32'hDEADBEEF}) begin n_fail++; $display("FAIL wake_data: got %0h want 00000055deadbeef", iss_data_o); end
        next_cycle();
        #1;
`endif
        n_cmp++; if (iss_valid_o !== 1'b1 || iss_ctrl_o !== 64'h11) begin n_fail++; $display("FAIL wake_younger: got v=%0b ctrl=%0h want v=1 ctrl=11", iss_valid_o, iss_ctrl_o); end
        next_cycle();
        n_cmp++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL wake_empty: got %0d want 0", count_o); end
    endtask

    task automatic test_dispatch_wakeup();
        do_reset();
        set_lane(0, 64'h20, 32'hFFFF, 32'h77, 1'b0, 1'b1, 6'd3, 6'd0);
        set_cdb(0, 6'd3, 32'h1234);
        set_cdb(1, 6'd3, 32'h9999);
        iss_ready_i = 1'b1;
        #1;
        n_cmp++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL dwake_empty: got %0b want 0", iss_valid_o); end
        next_cycle();
        drive_idle(); iss_ready_i = 1'b1;
        #1;
        n_cmp++; if (iss_valid_o !== 1'b1 || iss_ctrl_o !== 64'h20) begin n_fail++; $display("FAIL dwake_issue: got v=%0b ctrl=%0h want v=1 ctrl=20", iss_valid_o, iss_ctrl_o); end
        n_cmp++; if (iss_data_o !== {32'h77, 32'h1234}) begin n_fail++; $display("FAIL dwake_data: got %0h want 0000007700001234", iss_data_o); end
        next_cycle();
        n_cmp++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL dwake_empty_after: got %0d want 0", count_o); end
    endtask

    task automatic test_wrap();
        logic [CTRL_W-1:0] got[$];
        do_reset();
        for (int cyc = 0; cyc < 30; cyc++) begin
            drive_idle();
            if (cyc < 20) set_lane(cyc % 2, 64'h0C00 + 64'(cyc), 32'(cyc), 32'(cyc), 1'b1, 1'b1, 6'd0, 6'd0);
            iss_ready_i = (cyc % 5) != 3;
            #1;
            if (iss_valid_o && iss_ready_i) got.push_back(iss_ctrl_o);
            next_cycle();
        end
        n_cmp++; if (got.size() != 20) begin n_fail++; $display("FAIL wrap_count: got %0d issued want 20", got.size()); end
        for (int i = 0; i < got.size() && i < 20; i++) begin
            n_cmp++; if (got[i] !== 64'h0C00 + 64'(i)) begin n_fail++; $display("FAIL wrap_order_%0d: got %0h want %0h", i, got[i], 64'h0C00 + 64'(i)); end
        end
        n_cmp++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL wrap_empty: got %0d want 0", count_o); end
    endtask

    task automatic test_flush();
        do_reset();
        set_lane(0, 64'h30, 32'h0, 32'h0, 1'b0, 1'b0, 6'd1, 6'd2);
        set_lane(1, 64'h31, 32'h0, 32'h0, 1'b0, 1'b1, 6'd1, 6'd0);
        next_cycle();
        drive_idle();
        set_lane(0, 64'h32, 32'h0, 32'h0, 1'b0, 1'b0, 6'd2, 6'd2);
        next_cycle();
        drive_idle();
        #1;
        n_cmp++; if (count_o !== 4'd3 || iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_setup: got cnt=%0d v=%0b want cnt=3 v=0", count_o, iss_valid_o); end
        for (int k = 0; k < 3; k++) begin
            drive_idle();
            flush_i = 1'b1; iss_ready_i = 1'b1;
            set_lane(0, 64'hEE, 32'h0, 32'h0, 1'b1, 1'b1, 6'd0, 6'd0);
            set_lane(1, 64'hEF, 32'h0, 32'h0, 1'b1, 1'b1, 6'd0, 6'd0);
            #1;
            n_cmp++; if (p_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_pready_%0d: got %0b want 0", k, p_ready_o); end
            n_cmp++; if (iss_valid_o !== 1'b1 || iss_ctrl_o !== 64'h30 + 64'(k)) begin n_fail++; $display("FAIL flush_issue_%0d: got v=%0b ctrl=%0h want v=1 ctrl=%0h", k, iss_valid_o, iss_ctrl_o, 64'h30 + 64'(k)); end
            next_cycle();
        end
        #1;
        n_cmp++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_drained: got %0b want 0", iss_valid_o); end
        drive_idle();
        #1;
        n_cmp++; if (count_o !== 4'd0 || p_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_resume: got cnt=%0d prdy=%0b want cnt=0 prdy=1", count_o, p_ready_o); end
    endtask

    task automatic test_random();
        int               sz;
        bit               exp_pr, exp_v;
        bit [1:0]         hr;
        logic [DATA_W-1:0] hd [2];
        logic [DATA_W-1:0] cd;
        ment_t            ent;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            drive_idle();
            for (int l = 0; l < DW; l++)
                if ($urandom_range(0, 1) == 1)
                    set_lane(l, {$urandom, $urandom}, $urandom, $urandom,
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)));
            for (int l = 0; l < CW; l++)
                if ($urandom_range(0, 1) == 1) set_cdb(l, 6'($urandom_range(0, 3)), $urandom);
            iss_ready_i = ($urandom_range(0, 3) != 0);
            flush_i     = ($urandom_range(0, 15) == 0);
            #1;
            sz     = mq.size();
            exp_pr = ((IQ_SIZE - sz) >= DW) && !flush_i;
            hr = 2'b00;
            for (int o = 0; o < 2; o++) begin
                hd[o] = '0;
                if (sz > 0) begin
                    if (mq[0].r[o]) begin
                        hr[o] = 1'b1; hd[o] = mq[0].d[o];
`ifdef WIRED_LSU_IQ_CDB_BYPASS_EN
                    end else if (cdb_lookup(mq[0].t[o], cd)) begin
                        hr[o] = 1'b1; hd[o] = cd;
`endif
                    end
                end
            end
            exp_v = (sz > 0) && ((hr[0] && hr[1]) || flush_i);
            n_cmp++; if (count_o !== 4'(sz)) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, count_o, sz); end
            n_cmp++; if (p_ready_o !== exp_pr) begin n_fail++; $display("FAIL rnd_pready@%0d: got %0b want %0b", cyc, p_ready_o, exp_pr); end
            n_cmp++; if (iss_valid_o !== exp_v) begin n_fail++; $display("FAIL rnd_issv@%0d: got %0b want %0b", cyc, iss_valid_o, exp_v); end
            if (exp_v) begin
                n_cmp++; if (iss_ctrl_o !== mq[0].c) begin n_fail++; $display("FAIL rnd_ctrl@%0d: got %0h want %0h", cyc, iss_ctrl_o, mq[0].c); end
                for (int o = 0; o < 2; o++)
                    if (hr[o]) begin
                        n_cmp++; if (iss_data_o[o*DATA_W +: DATA_W] !== hd[o]) begin n_fail++; $display("FAIL rnd_data%0d@%0d: got %0h want %0h", o, cyc, iss_data_o[o*DATA_W +: DATA_W], hd[o]); end
                    end
            end
            @(posedge clk);
            if (exp_v && iss_ready_i) void'(mq.pop_front());
            for (int i = 0; i < mq.size(); i++) begin
                ent = mq[i];
                for (int o = 0; o < 2; o++)
                    if (!ent.r[o] && cdb_lookup(ent.t[o], cd)) begin ent.r[o] = 1'b1; ent.d[o] = cd; end
                mq[i] = ent;
            end
            if (exp_pr)
                for (int l = 0; l < DW; l++)
                    if (p_valid_i[l]) begin
                        ent.c = p_ctrl_i[l*CTRL_W +: CTRL_W];
                        for (int o = 0; o < 2; o++) begin
                            ent.t[o] = p_tag_i[(2*l+o)*TAG_W +: TAG_W];
                            ent.d[o] = p_data_i[(2*l+o)*DATA_W +: DATA_W];
                            ent.r[o] = p_rdy_i[2*l+o];
                            if (!ent.r[o] && cdb_lookup(ent.t[o], cd)) begin ent.r[o] = 1'b1; ent.d[o] = cd; end
                        end
                        mq.push_back(ent);
                    end
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_basic_issue();
        test_fill();
        test_stored_wakeup();
        test_dispatch_wakeup();
        test_wrap();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
